serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/add1.sv | 13 +
 rtl/serial_adder.sv | 134 +++++++++++++
 tb/tb_serial_adder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add1.sv
// One-bit full-adder cell.
module add1 (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell applied LSB first over N clock edges,
// with a valid/ready handshake on both the operand and result sides.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] sum,
    output logic         c_out
);

    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  sum_r;
    logic [N-1:0]  sum_shift_s;
    logic          carry_r;
    logic          c_out_r;
    logic [CW-1:0] cnt_r;
    logic          cell_sum_s;
    logic          cell_carry_s;

    add1 u_add1 (
        .a     (a_r[0]),
        .b     (b_r[0]),
        .c_in  (carry_r),
        .sum   (cell_sum_s),
        .c_out (cell_carry_s)
    );

    // New sum bits enter at the MSB so the first (LSB) bit lands at bit 0 after N shifts.
    generate
        if (N == 1) begin : g_one
            assign sum_shift_s = cell_sum_s;
        end else begin : g_multi
            assign sum_shift_s = {cell_sum_s, sum_r[N-1:1]};
        end
    endgenerate

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_valid) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture and one bit of addition per RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            c_out_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= c_in;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> 1'b1;
                    b_r     <= b_r >> 1'b1;
                    sum_r   <= sum_shift_s;
                    carry_r <= cell_carry_s;
                    cnt_r   <= cnt_r + ONE;
                    if (cnt_r == LAST) begin
                        c_out_r <= cell_carry_s;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ready = (state_r == IDLE);
    assign o_valid = (state_r == DONE);
    assign sum     = sum_r;
    assign c_out   = c_out_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (N=8 and N=1 instances) with a cycle-level reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       iv8 = 1'b0, ir8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       or8, ov8, c_out8;
    logic [7:0] sum8;

    logic       iv1 = 1'b0, ir1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = 1'b0, b1 = 1'b0;
    logic       or1, ov1, c_out1;
    logic [0:0] sum1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .i_valid(iv8), .o_ready(or8), .a(a8), .b(b8),
        .c_in(cin8), .o_valid(ov8), .i_ready(ir8), .sum(sum8), .c_out(c_out8)
    );

    serial_adder #(.N(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_valid(iv1), .o_ready(or1), .a(a1), .b(b1),
        .c_in(cin1), .o_valid(ov1), .i_ready(ir1), .sum(sum1), .c_out(c_out1)
    );

    // Reference model: an accepted operation becomes valid N edges later and stays until taken.
    localparam int NW [2] = '{8, 1};
    logic       m_ready [2] = '{1'b1, 1'b1};
    logic       m_valid [2] = '{1'b0, 1'b0};
    int         m_left  [2] = '{0, 0};
    logic [8:0] m_pend  [2] = '{9'd0, 9'd0};
    logic [8:0] m_res   [2] = '{9'd0, 9'd0};
    logic [8:0] m_in    [2];
    logic       m_iv    [2];
    logic       m_ir    [2];

    assign m_in[0] = 9'(a8) + 9'(b8) + 9'(cin8);
    assign m_in[1] = 9'(a1) + 9'(b1) + 9'(cin1);
    assign m_iv[0] = iv8;
    assign m_iv[1] = iv1;
    assign m_ir[0] = ir8;
    assign m_ir[1] = ir1;

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_ready[k] <= 1'b1;
                m_valid[k] <= 1'b0;
                m_left[k]  <= 0;
                m_res[k]   <= 9'd0;
            end else if (m_ready[k]) begin
                if (m_iv[k]) begin
                    m_pend[k]  <= m_in[k];
                    m_left[k]  <= NW[k];
                    m_ready[k] <= 1'b0;
                end
            end else if (m_left[k] > 1) begin
                m_left[k] <= m_left[k] - 1;
            end else if (m_left[k] == 1) begin
                m_left[k]  <= 0;
                m_valid[k] <= 1'b1;
                m_res[k]   <= m_pend[k];
            end else if (m_valid[k] && m_ir[k]) begin
                m_valid[k] <= 1'b0;
                m_ready[k] <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("m8_ready", 32'(or8), 32'(m_ready[0]));
        chk("m8_valid", 32'(ov8), 32'(m_valid[0]));
        if (m_ready[0] || m_valid[0]) begin
            chk("m8_result", 32'({c_out8, sum8}), 32'(m_res[0]));
        end
        chk("m1_ready", 32'(or1), 32'(m_ready[1]));
        chk("m1_valid", 32'(ov1), 32'(m_valid[1]));
        if (m_ready[1] || m_valid[1]) begin
            chk("m1_result", 32'({c_out1, sum1}), 32'(m_res[1][1:0]));
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [8:0] exp, input int hold, input bit keep);
        int lat;
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1; ir8 = 1'b0;
        @(posedge clk); #2;
        if (!keep) iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 50) begin
            if (keep) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            @(posedge clk); #2;
            lat++;
        end
        chk("latency8", 32'(lat), 32'd8);
        chk("result8", 32'({c_out8, sum8}), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #2;
            chk("hold_valid8", 32'(ov8), 32'd1);
            chk("hold_result8", 32'({c_out8, sum8}), 32'(exp));
        end
        ir8 = 1'b1;
        @(posedge clk); #2;
        ir8 = 1'b0; iv8 = 1'b0;
        chk("idle_after8", 32'(or8), 32'd1);
        chk("kept8", 32'({c_out8, sum8}), 32'(exp));
    endtask

    initial begin
        #3;
        chk("reset_ready", 32'(or8), 32'd1);
        chk("reset_valid", 32'(ov8), 32'd0);
        chk("reset_result", 32'({c_out8, sum8}), 32'd0);
        #9 rst_n = 1'b1;

        op8(8'hFF, 8'h01, 1'b0, 9'h100, 0, 1'b0);
        op8(8'h5A, 8'h3C, 1'b1, 9'h097, 5, 1'b0);
        op8(8'hA5, 8'h0F, 1'b0, 9'h0B4, 0, 1'b1);

        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #2;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(ov8), 32'd0);
        chk("abort_ready", 32'(or8), 32'd1);
        chk("abort_result", 32'({c_out8, sum8}), 32'd0);
        #3 rst_n = 1'b1;
        op8(8'h80, 8'h80, 1'b1, 9'h101, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            op8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), 0, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            int lat;
            v = 3'(i);
            a1 = v[2:2]; b1 = v[1:1]; cin1 = v[0]; iv1 = 1'b1;
            @(posedge clk); #2;
            iv1 = 1'b0;
            lat = 0;
            while (!ov1 && lat < 20) begin
                @(posedge clk); #2;
                lat++;
            end
            chk("latency1", 32'(lat), 32'd1);
            chk("result1", 32'({c_out1, sum1}), 32'(v[2] + v[1] + v[0]));
            ir1 = 1'b1;
            @(posedge clk); #2;
            ir1 = 1'b0;
            chk("idle_after1", 32'(or1), 32'd1);
        end

        repeat (2) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
